// File: rtl/w0rm_mem_arb_pkg.sv
// Shared types and sizing helpers for the W0RM memory-port arbiter.
package w0rm_mem_arb_pkg;

    // Requester identity; also the value carried in bit 0 of the memory user field.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    localparam int TAG_WIDTH = 1;

    // Watchdog counter width (only used when W0RM_MEM_ARB_TIMEOUT_EN is defined).
    localparam int WD_WIDTH = 16;

    // Bits needed to hold an outstanding count of 0..max_out.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/w0rm_rr_arbiter2.sv
// Two-way round-robin grant. On a tie the requester not served last wins;
// the history bit only moves when a granted request is actually accepted.
module w0rm_rr_arbiter2
    import w0rm_mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    req_id_e last_grant_q, last_grant_d;

    // Grant decode: single requester wins outright, tie goes to the other side of last_grant.
    always_comb begin
        grant_o      = req_i;
        last_grant_d = last_grant_q;
        if (req_i == 2'b11) begin
            grant_o = (last_grant_q == REQ_B) ? 2'b01 : 2'b10;
        end
        if (accept_i) begin
            last_grant_d = grant_o[1] ? REQ_B : REQ_A;
        end
    end

    // History register; resets to B so A wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_grant_q <= REQ_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/w0rm_memory_arbiter.sv
// Shares memory port A between instruction fetch (A) and data (B) requesters.
// Handshake: a request transfers in a cycle where rq_x_valid_i and rq_x_ready_o
// are both high; ready is combinational and never depends on rq_x_valid_i of the
// same requester except through the grant. Responses are single-cycle strobes.
// Optional watchdog: define W0RM_MEM_ARB_TIMEOUT_EN to add timeout_o.
module w0rm_memory_arbiter
    import w0rm_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                    mem_clk,
    input  logic                    cpu_reset,
    input  logic                    rq_a_valid_i,
    input  logic                    rq_a_read_i,
    input  logic                    rq_a_write_i,
    input  logic [ADDR_WIDTH-1:0]   rq_a_addr_i,
    input  logic [DATA_WIDTH-1:0]   rq_a_data_i,
    input  logic [USER_WIDTH-1:0]   rq_a_user_i,
    output logic                    rq_a_ready_o,
    output logic                    rq_a_valid_o,
    output logic [DATA_WIDTH-1:0]   rq_a_data_o,
    output logic [USER_WIDTH-1:0]   rq_a_user_o,
    input  logic                    rq_b_valid_i,
    input  logic                    rq_b_read_i,
    input  logic                    rq_b_write_i,
    input  logic [ADDR_WIDTH-1:0]   rq_b_addr_i,
    input  logic [DATA_WIDTH-1:0]   rq_b_data_i,
    input  logic [USER_WIDTH-1:0]   rq_b_user_i,
    output logic                    rq_b_ready_o,
    output logic                    rq_b_valid_o,
    output logic [DATA_WIDTH-1:0]   rq_b_data_o,
    output logic [USER_WIDTH-1:0]   rq_b_user_o,
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
    output logic                    timeout_o,
`endif
    output logic                    mem_valid_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_data_o,
    output logic [USER_WIDTH:0]     mem_user_o,
    input  logic                    mem_valid_i,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    input  logic [USER_WIDTH:0]     mem_user_i
);

    localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]      count_q, count_d;
    logic [1:0]            grant;
    logic                  slot_free, accept_a, accept_b, accept, resp_ok;
    req_id_e               resp_tag;

    logic                  mem_valid_q, mem_read_q, mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [USER_WIDTH:0]   mem_user_q;

    logic                  rq_a_valid_q, rq_b_valid_q;
    logic [DATA_WIDTH-1:0] rq_a_data_q, rq_b_data_q;
    logic [USER_WIDTH-1:0] rq_a_user_q, rq_b_user_q;

    // A slot is free only out of reset and below the in-flight limit; a response
    // this cycle is reflected in count_q next cycle, not here.
    assign slot_free    = cpu_reset && (count_q < CNT_MAX);
    assign rq_a_ready_o = grant[0] && slot_free;
    assign rq_b_ready_o = grant[1] && slot_free;
    assign accept_a     = rq_a_valid_i && rq_a_ready_o;
    assign accept_b     = rq_b_valid_i && rq_b_ready_o;
    assign accept       = accept_a || accept_b;

    // Responses with nothing in flight (stray or pre-reset) are discarded.
    assign resp_ok  = mem_valid_i && (count_q != '0);
    assign resp_tag = req_id_e'(mem_user_i[0]);

    w0rm_rr_arbiter2 u_rr (
        .clk_i    (mem_clk),
        .rst_ni   (cpu_reset),
        .req_i    ({rq_b_valid_i, rq_a_valid_i}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // Register the accepted request onto the memory port; valid is a one-cycle pulse.
    always_ff @(posedge mem_clk) begin
        if (!cpu_reset) begin
            mem_valid_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_user_q  <= '0;
        end else begin
            mem_valid_q <= accept;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (accept_b) begin
                mem_read_q  <= rq_b_read_i;
                mem_write_q <= rq_b_write_i;
                mem_addr_q  <= rq_b_addr_i;
                mem_data_q  <= rq_b_data_i;
                mem_user_q  <= {rq_b_user_i, TAG_WIDTH'(REQ_B)};
            end else if (accept_a) begin
                mem_read_q  <= rq_a_read_i;
                mem_write_q <= rq_a_write_i;
                mem_addr_q  <= rq_a_addr_i;
                mem_data_q  <= rq_a_data_i;
                mem_user_q  <= {rq_a_user_i, TAG_WIDTH'(REQ_A)};
            end
        end
    end

    // Route a valid response to the requester named by its tag, one cycle later.
    always_ff @(posedge mem_clk) begin
        if (!cpu_reset) begin
            rq_a_valid_q <= 1'b0;
            rq_b_valid_q <= 1'b0;
            rq_a_data_q  <= '0;
            rq_b_data_q  <= '0;
            rq_a_user_q  <= '0;
            rq_b_user_q  <= '0;
        end else begin
            rq_a_valid_q <= resp_ok && (resp_tag == REQ_A);
            rq_b_valid_q <= resp_ok && (resp_tag == REQ_B);
            if (resp_ok && (resp_tag == REQ_A)) begin
                rq_a_data_q <= mem_data_i;
                rq_a_user_q <= mem_user_i[USER_WIDTH:1];
            end
            if (resp_ok && (resp_tag == REQ_B)) begin
                rq_b_data_q <= mem_data_i;
                rq_b_user_q <= mem_user_i[USER_WIDTH:1];
            end
        end
    end

`ifdef W0RM_MEM_ARB_TIMEOUT_EN
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);
    logic [WD_WIDTH-1:0] wd_q, wd_d;
    logic                timeout_q, timeout_d;

    // Watchdog: count silent cycles while work is in flight; reaching the limit
    // pulses timeout and flushes the in-flight count.
    always_comb begin
        wd_d      = '0;
        timeout_d = 1'b0;
        if ((count_q != '0) && !mem_valid_i) begin
            if (wd_q + WD_WIDTH'(1) == WD_LIMIT) begin
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q + WD_WIDTH'(1);
            end
        end
    end

    // Watchdog state.
    always_ff @(posedge mem_clk) begin
        if (!cpu_reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`endif

    // Outstanding count: simultaneous accept and response cancel out; a flush
    // keeps only a request accepted in the flush cycle itself.
    always_comb begin
        count_d = count_q;
        if (accept && !resp_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && resp_ok) begin
            count_d = count_q - CNT_W'(1);
        end
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
        if (timeout_d) begin
            count_d = accept ? CNT_W'(1) : '0;
        end
`endif
    end

    // Outstanding count register.
    always_ff @(posedge mem_clk) begin
        if (!cpu_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign mem_valid_o  = mem_valid_q;
    assign mem_read_o   = mem_read_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_user_o   = mem_user_q;
    assign rq_a_valid_o = rq_a_valid_q;
    assign rq_a_data_o  = rq_a_data_q;
    assign rq_a_user_o  = rq_a_user_q;
    assign rq_b_valid_o = rq_b_valid_q;
    assign rq_b_data_o  = rq_b_data_q;
    assign rq_b_user_o  = rq_b_user_q;

endmodule
